// File: rtl/pong_paddle_ctrl.sv
// Pong paddle control: button synchronisation/debounce and per-player
// paddle position integration, updated once per frame on frame_tick.

// Two-flop synchroniser followed by a counting debouncer for one raw button.
module pong_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Synchronise the raw input, then flip the level only after it has
    // disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// One player's movement FSM and clamped paddle position.
module pong_paddle_fsm #(
    parameter int SCREEN_H     = 480,
    parameter int BORDER_W     = 10,
    parameter int PADDLE_H     = 96,
    parameter int INIT_Y       = 192,
    parameter int SPEED_SLOW   = 1,
    parameter int SPEED_FAST   = 4,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       down,
    output logic [9:0] y,
    output logic       fast
);
    localparam logic [10:0] Y_MIN   = 11'(BORDER_W);
    localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - BORDER_W - PADDLE_H);
    localparam logic [10:0] V_SLOW  = 11'(SPEED_SLOW);
    localparam logic [10:0] V_FAST  = 11'(SPEED_FAST);
    localparam int          HW      = $clog2(ACCEL_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(ACCEL_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_SLOW = 2'd1,
        MOVE_FAST = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [9:0]    y_q, y_n;
    logic [HW-1:0] hold, hold_n;
    logic          dir_dn, dir_dn_n;
    logic          cmd_up, cmd_dn;
    logic [10:0]   y_ext;
    logic [10:0]   speed;

    // State, position and hold counter advance only on the frame tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            y_q    <= 10'(INIT_Y);
            hold   <= '0;
            dir_dn <= 1'b0;
        end else if (frame_tick) begin
            state  <= state_n;
            y_q    <= y_n;
            hold   <= hold_n;
            dir_dn <= dir_dn_n;
        end
    end

    // Next state, step size and clamped next position.
    always_comb begin
        state_n  = state;
        hold_n   = hold;
        dir_dn_n = dir_dn;
        speed    = '0;
        cmd_up   = up & ~down;
        cmd_dn   = down & ~up;
        y_ext    = {1'b0, y_q};

        if (!(cmd_up || cmd_dn)) begin
            state_n = IDLE;
            hold_n  = '0;
        end else if ((cmd_up && y_ext <= Y_MIN) || (cmd_dn && y_ext >= Y_MAX)) begin
            // Already parked at the clamp in the commanded direction.
            state_n = IDLE;
            hold_n  = '0;
        end else if (state == IDLE || dir_dn != cmd_dn) begin
            state_n  = MOVE_SLOW;
            hold_n   = HW'(1);
            dir_dn_n = cmd_dn;
            speed    = V_SLOW;
        end else if (state == MOVE_SLOW && hold >= HOLD_MAX) begin
            state_n = MOVE_FAST;
            speed   = V_FAST;
        end else if (state == MOVE_SLOW) begin
            hold_n = hold + 1'b1;
            speed  = V_SLOW;
        end else begin
            speed = V_FAST;
        end

        y_n = y_q;
        if (speed != '0) begin
            if (dir_dn_n) begin
                y_n = (y_ext + speed > Y_MAX) ? 10'(Y_MAX) : 10'(y_ext + speed);
            end else begin
                y_n = (y_ext < Y_MIN + speed) ? 10'(Y_MIN) : 10'(y_ext - speed);
            end
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        y    = y_q;
        fast = (state == MOVE_FAST);
    end
endmodule

// Top level: four debounced buttons feeding two independent paddle FSMs.
module pong_paddle_ctrl #(
    parameter int SCREEN_H        = 480,
    parameter int BORDER_W        = 10,
    parameter int PADDLE_H        = 96,
    parameter int INIT_Y          = 192,
    parameter int SPEED_SLOW      = 1,
    parameter int SPEED_FAST      = 4,
    parameter int ACCEL_FRAMES    = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    output logic [9:0] p1_y,
    output logic [9:0] p2_y,
    output logic       p1_fast,
    output logic       p2_fast
);
    logic db_u, db_d, db_l, db_r;

    pong_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
        .clk(clk), .reset(reset), .raw(btnU), .level(db_u));
    pong_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
        .clk(clk), .reset(reset), .raw(btnD), .level(db_d));
    pong_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .reset(reset), .raw(btnL), .level(db_l));
    pong_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .reset(reset), .raw(btnR), .level(db_r));

    pong_paddle_fsm #(
        .SCREEN_H(SCREEN_H), .BORDER_W(BORDER_W), .PADDLE_H(PADDLE_H),
        .INIT_Y(INIT_Y), .SPEED_SLOW(SPEED_SLOW), .SPEED_FAST(SPEED_FAST),
        .ACCEL_FRAMES(ACCEL_FRAMES)
    ) u_p1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .up(db_u), .down(db_d), .y(p1_y), .fast(p1_fast));

    pong_paddle_fsm #(
        .SCREEN_H(SCREEN_H), .BORDER_W(BORDER_W), .PADDLE_H(PADDLE_H),
        .INIT_Y(INIT_Y), .SPEED_SLOW(SPEED_SLOW), .SPEED_FAST(SPEED_FAST),
        .ACCEL_FRAMES(ACCEL_FRAMES)
    ) u_p2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .up(db_l), .down(db_r), .y(p2_y), .fast(p2_fast));
endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Directed bench for pong_paddle_ctrl with short debounce and acceleration.
`timescale 1ns/1ps
module tb_pong_paddle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic [9:0] p1_y, p2_y;
    logic       p1_fast, p2_fast;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  btn;    // {U, D, L, R}
        int          settle;
        int          p1;
        int          p2;
        int          f1;
        int          f2;
    } vec_t;

    vec_t vecs[22];

    pong_paddle_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .ACCEL_FRAMES(3)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
        .p1_y(p1_y), .p2_y(p2_y), .p1_fast(p1_fast), .p2_fast(p2_fast));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btnU, btnD, btnL, btnR} = b;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        set_btn(4'b0000);
        @(negedge clk) reset = 1'b0;
        check("rst p1_y", int'(p1_y), 192);
        check("rst p2_y", int'(p2_y), 192);
        check("rst p1_fast", int'(p1_fast), 0);
        check("rst p2_fast", int'(p2_fast), 0);
    endtask

    initial begin
        int exp1, exp2, ef;

        vecs[0]  = '{4'b0000, 8, 192, 192, 0, 0};
        vecs[1]  = '{4'b0000, 1, 192, 192, 0, 0};
        vecs[2]  = '{4'b0000, 1, 192, 192, 0, 0};
        vecs[3]  = '{4'b0000, 1, 192, 192, 0, 0};
        vecs[4]  = '{4'b0000, 1, 192, 192, 0, 0};
        vecs[5]  = '{4'b0100, 8, 193, 192, 0, 0};
        vecs[6]  = '{4'b0100, 1, 194, 192, 0, 0};
        vecs[7]  = '{4'b0100, 1, 195, 192, 0, 0};
        vecs[8]  = '{4'b0100, 1, 199, 192, 1, 0};
        vecs[9]  = '{4'b0100, 1, 203, 192, 1, 0};
        vecs[10] = '{4'b0000, 8, 203, 192, 0, 0};
        vecs[11] = '{4'b1100, 8, 203, 192, 0, 0};
        vecs[12] = '{4'b1100, 1, 203, 192, 0, 0};
        vecs[13] = '{4'b1100, 1, 203, 192, 0, 0};
        vecs[14] = '{4'b1100, 1, 203, 192, 0, 0};
        vecs[15] = '{4'b1100, 1, 203, 192, 0, 0};
        vecs[16] = '{4'b0100, 8, 204, 192, 0, 0};
        vecs[17] = '{4'b0010, 8, 204, 191, 0, 0};
        vecs[18] = '{4'b0010, 1, 204, 190, 0, 0};
        vecs[19] = '{4'b0010, 1, 204, 189, 0, 0};
        vecs[20] = '{4'b0010, 1, 204, 185, 0, 1};
        vecs[21] = '{4'b0010, 1, 204, 181, 0, 1};

        wait_clks(3);
        do_reset();

        for (int i = 0; i < 22; i++) begin
            set_btn(vecs[i].btn);
            wait_clks(vecs[i].settle);
            do_tick();
            check($sformatf("vec%0d p1_y", i), int'(p1_y), vecs[i].p1);
            check($sformatf("vec%0d p2_y", i), int'(p2_y), vecs[i].p2);
            check($sformatf("vec%0d p1_fast", i), int'(p1_fast), vecs[i].f1);
            check($sformatf("vec%0d p2_fast", i), int'(p2_fast), vecs[i].f2);
        end

        // Player 2 keeps moving up at full speed into the top clamp.
        exp2 = 181;
        for (int i = 0; i < 200; i++) begin
            do_tick();
            if (exp2 > 10) begin
                exp2 = (exp2 > 14) ? exp2 - 4 : 10;
                ef = 1;
            end else begin
                ef = 0;
            end
            check($sformatf("clamp%0d p2_y", i), int'(p2_y), exp2);
            check($sformatf("clamp%0d p2_fast", i), int'(p2_fast), ef);
        end
        check("clamp p1_y", int'(p1_y), 204);

        // Short glitches on btnU never reach the debounced level.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) btnU = 1'b1;
            wait_clks(2);
            btnU = 1'b0;
            wait_clks(6);
            do_tick();
            check($sformatf("glitch%0d p1_y", i), int'(p1_y), 192);
            check($sformatf("glitch%0d p1_fast", i), int'(p1_fast), 0);
        end

        // Drive player 1 to 300 in MOVE_FAST, then reset on a frame tick.
        set_btn(4'b0100);
        wait_clks(8);
        do_tick();
        check("tap p1_y", int'(p1_y), 193);
        set_btn(4'b0000);
        wait_clks(8);
        do_tick();
        check("tap idle p1_y", int'(p1_y), 193);
        check("tap idle p1_fast", int'(p1_fast), 0);
        set_btn(4'b0100);
        wait_clks(8);
        exp1 = 193;
        for (int i = 0; i < 29; i++) begin
            do_tick();
            exp1 += (i < 3) ? 1 : 4;
            check($sformatf("run%0d p1_y", i), int'(p1_y), exp1);
            check($sformatf("run%0d p1_fast", i), int'(p1_fast), (i < 3) ? 0 : 1);
        end
        check("run end p1_y", int'(p1_y), 300);

        @(negedge clk);
        reset = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        frame_tick = 1'b0;
        check("rst tick p1_y", int'(p1_y), 192);
        check("rst tick p1_fast", int'(p1_fast), 0);
        check("rst tick p2_y", int'(p2_y), 192);
        do_tick();
        check("post rst p1_y", int'(p1_y), 192);
        wait_clks(8);
        do_tick();
        check("redebounce p1_y", int'(p1_y), 193);
        check("redebounce p1_fast", int'(p1_fast), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pong_paddle_ctrl.md
Name: pong_paddle_ctrl

Overview:
Upstream control stage for the Pong renderer. It turns the four raw push-buttons into debounced per-player up/down commands and integrates them into registered paddle top-edge Y positions (p1_y, p2_y). Positions change only once per frame, on the frame tick, so the renderer never sees a paddle move mid-frame. The renderer consumes p1_y/p2_y directly as its paddle positions.

Parameters:
SCREEN_H, 480, visible lines
BORDER_W, 10, border thickness in pixels (top and bottom)
PADDLE_H, 96, paddle height in pixels
INIT_Y, 192, paddle top Y after reset
SPEED_SLOW, 1, pixels per frame while in MOVE_SLOW
SPEED_FAST, 4, pixels per frame while in MOVE_FAST
ACCEL_FRAMES, 16, consecutive moving frames before MOVE_SLOW becomes MOVE_FAST
DEBOUNCE_CYCLES, 1000000, stable clk cycles a button must hold before its debounced level changes (10 ms at 100 MHz)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high; sampled on the rising edge of clk
frame_tick  in  1  single-clk pulse once per frame, asserted at y==480, x==0 and qualified by the pixel tick
btnU  in  1  raw button, player 1 up
btnD  in  1  raw button, player 1 down
btnL  in  1  raw button, player 2 up
btnR  in  1  raw button, player 2 down
p1_y  out  10  player 1 paddle top row
p2_y  out  10  player 2 paddle top row
p1_fast  out  1  high while player 1 is in MOVE_FAST
p2_fast  out  1  high while player 2 is in MOVE_FAST

Behaviour:
- Reset: p1_y = p2_y = INIT_Y; p1_fast = p2_fast = 0; both FSMs go to IDLE; debounced levels = 0; synchronizers and counters = 0. Reset takes priority over frame_tick in the same cycle.
- Each button passes through a 2-FF synchronizer and then a debouncer. The debouncer counter clears whenever the synchronized input equals the current debounced level. Otherwise it increments. When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Input latency: a clean edge appears on the debounced level 2 + DEBOUNCE_CYCLES clk cycles after the raw edge. A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Per-player command is computed from the debounced levels. up-only gives UP, down-only gives DOWN. Both pressed or neither pressed gives NONE.
- Per-player FSM state and position update only on clk edges where frame_tick = 1. In all other cycles they hold.
  - IDLE: the command is NONE, or the command is UP while at the upper clamp, or DOWN while at the lower clamp.
  - MOVE_SLOW: entered on the first frame with a non-NONE command. It moves by SPEED_SLOW and increments a hold counter.
  - MOVE_FAST: entered when the hold counter reaches ACCEL_FRAMES with the same command still held. It moves by SPEED_FAST.
  - Transition rules: NONE sends the FSM to IDLE and clears the hold counter. A change of direction (UP to DOWN) returns to MOVE_SLOW and restarts the hold counter at 1.
- Clamping: Y_MIN = BORDER_W (10); Y_MAX = SCREEN_H - BORDER_W - PADDLE_H (374).
  - Arithmetic is done in 11 bits so it cannot wrap.
  - UP: new_y = max(y - speed, Y_MIN).
  - DOWN: new_y = min(y + speed, Y_MAX).
  - Reaching a clamp does not change the FSM state that frame. The next frame at the clamp with the same command goes to IDLE and clears the hold counter.
- Output timing: p1_y/p2_y are registered and take their new value on the clk edge that samples frame_tick. They are stable for the whole following frame.
- p1_fast and p2_fast are registered, equal (state == MOVE_FAST), and update on the same edge as the position.
- The two players are fully independent. Simultaneous events on both players are processed in the same frame_tick cycle.
- Reset asserted mid-debounce or mid-move discards all history. After reset is released, movement resumes only after a fresh debounce.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4 and ACCEL_FRAMES=3.
- Reset then 5 frame_ticks with no buttons -> p1_y = p2_y = 192, p1_fast = p2_fast = 0 throughout.
- btnD held, then 1 frame_tick after debounce -> p1_y = 193. Further ticks: 194, 195; the next tick is MOVE_FAST giving 199, then 203, and p1_fast = 1 from that tick. p2_y stays 192.
- btnU glitch of 2 clk cycles repeated for 10 frames -> p1_y stays 192, no state change.
- btnL held for 200 frames -> p2_y decreases, clamps exactly at 10 and never goes below. The frame after clamping gives p2_fast = 0 (IDLE).
- btnU and btnD both held -> p1_y unchanged across 5 ticks. Releasing btnU leaves DOWN only: next tick gives +1 and the FSM restarts in MOVE_SLOW.
- With p1_y = 300 in MOVE_FAST, assert reset for 1 cycle coincident with frame_tick -> p1_y = 192, p1_fast = 0. A still-held button needs a full debounce before the next move.
